// File: rtl/pga_spi_target.sv
// pga_spi_target: SPI mode-0 target that receives one DW-bit gain word per
// chip-select frame. sck/cs_n/sdi are synchronized into clk, edges are found
// on the synchronized copies, and a small IDLE/SHIFT/OVERRUN FSM accepts
// exact-length frames and rejects short or long ones.
//
// Optional feature: define PGA_SPI_TARGET_READBACK_EN to add the sdo port,
// which shifts the current gain_o back out MSB first during the next frame.
//
// Ports:
//   clk          system clock (must be at least 4x sck)
//   rst          asynchronous active-high reset
//   sck          SPI clock, idle low, asynchronous
//   cs_n         SPI chip select, active low, asynchronous
//   sdi          SPI serial data in, MSB first, idle high
//   gain_o       last validly received word
//   valid_o      one-cycle pulse when gain_o updates
//   frame_err_o  one-cycle pulse on a rejected frame
//   busy_o       high while a frame is in progress
//   sdo          readback serial data (readback build only)
module pga_spi_target #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          cs_n,
  input  logic          sdi,
  output logic [DW-1:0] gain_o,
  output logic          valid_o,
  output logic          frame_err_o,
  output logic          busy_o
`ifdef PGA_SPI_TARGET_READBACK_EN
  ,
  output logic          sdo
`endif
);

  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] SHIFT   = 2'b01;
  localparam logic [1:0] OVERRUN = 2'b10;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_rise, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   prime_sr;
  logic                   armed;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] bit_count, bit_count_nxt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic [DW-1:0] gain_nxt;
  logic          valid_pend, valid_pend_nxt;
  logic          err_pend, err_pend_nxt;
`ifdef PGA_SPI_TARGET_READBACK_EN
  logic          sck_fall;
  logic [DW-1:0] tx, tx_nxt;
`endif

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  // A frame may only start once cs_n has been seen high through a fully
  // primed synchronizer; this drops frames already running at reset release.
  assign cs_fall  = ~cs_s & cs_d & armed;
`ifdef PGA_SPI_TARGET_READBACK_EN
  assign sck_fall = ~sck_s & sck_d;
`endif

  // Synchronizers, edge-detect delay copies and post-reset arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '1;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
      prime_sr <= '0;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
      prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (prime_sr[SYNC_STAGES] & cs_s);
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt      = state;
    bit_count_nxt  = bit_count;
    shreg_nxt      = shreg;
    gain_nxt       = gain_o;
    valid_pend_nxt = 1'b0;
    err_pend_nxt   = 1'b0;
`ifdef PGA_SPI_TARGET_READBACK_EN
    tx_nxt         = tx;
`endif
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt     = SHIFT;
          bit_count_nxt = '0;
`ifdef PGA_SPI_TARGET_READBACK_EN
          tx_nxt        = gain_o;
`endif
        end
      end
      SHIFT: begin
        // cs_n rising has priority over a coincident sck edge.
        if (cs_rise) begin
          state_nxt = IDLE;
          if (bit_count == CW'(DW)) begin
            gain_nxt       = shreg;
            valid_pend_nxt = 1'b1;
          end else begin
            err_pend_nxt = 1'b1;
          end
        end else if (sck_rise) begin
          if (bit_count == CW'(DW)) begin
            state_nxt = OVERRUN;
          end else begin
            shreg_nxt     = {shreg[DW-2:0], sdi_s};
            bit_count_nxt = bit_count + CW'(1);
          end
        end
`ifdef PGA_SPI_TARGET_READBACK_EN
        if (!cs_rise && sck_fall) begin
          tx_nxt = {tx[DW-2:0], 1'b1};
        end
`endif
      end
      OVERRUN: begin
        if (cs_rise) begin
          state_nxt    = IDLE;
          err_pend_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_count   <= '0;
      shreg       <= '0;
      gain_o      <= '0;
      valid_pend  <= 1'b0;
      err_pend    <= 1'b0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef PGA_SPI_TARGET_READBACK_EN
      tx          <= '0;
      sdo         <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      bit_count   <= bit_count_nxt;
      shreg       <= shreg_nxt;
      gain_o      <= gain_nxt;
      valid_pend  <= valid_pend_nxt;
      err_pend    <= err_pend_nxt;
      valid_o     <= valid_pend;
      frame_err_o <= err_pend;
      busy_o      <= (state_nxt != IDLE);
`ifdef PGA_SPI_TARGET_READBACK_EN
      tx          <= tx_nxt;
      sdo         <= (state_nxt == IDLE) ? 1'b1 : tx_nxt[DW-1];
`endif
    end
  end

endmodule

// File: doc/pga_spi_target.md
PGA_SPI_TARGET -- requirements
Module: pga_spi_target

Interface
REQ-001 Parameter DW, default 8, frame width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sck/cs_n/sdi (legal ≥2).
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  SPI serial clock from initiator, idle low, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 sdi  input  1  serial data from initiator, MSB first, idle high.
REQ-008 gain_o  output  DW  last validly received word.
REQ-009 valid_o  output  1  one-cycle pulse when gain_o updates.
REQ-010 frame_err_o  output  1  one-cycle pulse on rejected frame.
REQ-011 busy_o  output  1  high while a frame is in progress.
REQ-012 sdo  output  1  readback serial data; present only with macro (see Configuration).

Function
REQ-013 sck, cs_n, sdi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on synchronized values against a one-cycle-delayed copy.
REQ-014 clk SHALL be ≥4x sck frequency (12.5 MHz sck -> clk ≥50 MHz); slower clk is unsupported.
REQ-015 Sampling: SPI mode 0; sdi sampled on synchronized sck rising edge, shifted into shift register MSB first.
REQ-016 States: IDLE, SHIFT, OVERRUN.
REQ-017 IDLE -> SHIFT only on synchronized cs_n falling edge; bit_count cleared to 0.
REQ-018 SHIFT: each sck rising edge shifts one bit, bit_count increments; on a rising edge with bit_count == DW -> OVERRUN, shift register not modified.
REQ-019 SHIFT/OVERRUN -> IDLE on synchronized cs_n rising edge.
REQ-020 On cs_n rising edge in SHIFT with bit_count == DW: gain_o <= shift register, valid_o pulses in the following cycle.
REQ-021 On cs_n rising edge in SHIFT with bit_count < DW, or in OVERRUN: gain_o unchanged, frame_err_o pulses in the following cycle.
REQ-022 Simultaneous synchronized sck rising and cs_n rising: cs_n rising wins; sck edge ignored.
REQ-023 Latency: valid_o/frame_err_o assert SYNC_STAGES+2 clk cycles after cs_n rises at the pin.
REQ-024 valid_o and frame_err_o SHALL never assert in the same cycle.
REQ-025 busy_o SHALL equal (state != IDLE).
REQ-026 sck edges while in IDLE SHALL be ignored.
REQ-027 bit_count width SHALL hold 0..DW without wrap.

Reset
REQ-028 rst SHALL force state IDLE, bit_count 0, shift register 0, gain_o 0, valid_o 0, frame_err_o 0, busy_o 0, sdo 1.
REQ-029 Synchronizer flops SHALL reset to sck 0, cs_n 1, sdi 1.
REQ-030 Reset mid-frame: partial frame discarded; if cs_n still low at release, remainder ignored until cs_n rises and falls again (no valid_o, no frame_err_o for that frame).

Configuration
REQ-031 Macro PGA_SPI_TARGET_READBACK_EN.
REQ-032 Defined: sdo port exists; on cs_n falling edge tx register loads gain_o and sdo drives its MSB; each synchronized sck falling edge in SHIFT shifts tx left; sdo = 1 in IDLE.
REQ-033 Undefined: sdo port and tx register absent; all other behaviour identical.

Verification
REQ-034 Send 8'hA5 (8 bits, sck 12.5 MHz, clk 100 MHz) -> gain_o = 8'hA5, one valid_o pulse, no frame_err_o, busy_o low after.
REQ-035 Send 5 bits then raise cs_n -> frame_err_o pulse, gain_o keeps prior value 8'hA5.
REQ-036 Send 9 bits 8'h3C+1 -> OVERRUN entered, frame_err_o pulse, gain_o unchanged.
REQ-037 Assert rst after 4 bits of 8'hFF with cs_n held low, release, finish frame -> no valid_o, no frame_err_o, gain_o = 0; next full frame 8'h12 -> gain_o = 8'h12.
REQ-038 With PGA_SPI_TARGET_READBACK_EN, gain_o = 8'h5A, send frame 8'h00 -> sdo bits 0,1,0,1,1,0,1,0 sampled on sck rising; gain_o = 8'h00 after.
